load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- CPU-side initiator for the word-wide data memory. It takes load/store requests from the MEM pipeline stage and runs them on a valid/ack memory port.
- Sub-word stores (sb, sh) are done as a read-modify-write, because memory accepts whole-word writes only.
- Loads are byte/halfword-extracted and sign- or zero-extended, then returned on a register-file writeback port.

Parameters:
- ADDR_W, 8, word-index width of mem_addr (256 words).
- TIMEOUT_CYCLES, 16, cycles to wait for mem_ack before abort; used only with LSU_TIMEOUT_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  high only in IDLE; accept = req_valid & req_ready at a rising edge.
- req_opcode  in  6  MIPS opcode.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_rt  in  5  load destination register.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  1 = write, 0 = read.
- mem_addr  out  ADDR_W  word index, equal to req_addr[ADDR_W+1:2]; upper bits ignored.
- mem_wdata  out  32  write word.
- mem_rdata  in  32  read word, valid when mem_ack is high.
- mem_ack  in  1  one-cycle completion from memory.
- wb_valid  out  1  one-cycle writeback pulse.
- wb_rd  out  5  writeback register.
- wb_data  out  32  writeback data.
- st_done  out  1  one-cycle store-complete pulse.
- err_valid  out  1  one-cycle error pulse.
- err_code  out  2  01 illegal opcode, 10 misaligned, 11 timeout.

Behaviour:
- Reset values: all registered outputs 0, state IDLE. req_ready = (state==IDLE), so it reads 1 during and after reset. Reset mid-transaction drops the transaction with no writeback or done pulse.
- Opcodes:
  - Loads: lb 0x20, lh 0x21, lw 0x23, lbu 0x24, lhu 0x25.
  - Stores: sb 0x28, sh 0x29, sw 0x2B.
  - Anything else: err 01.
- Alignment: lh/lhu/sh need addr[0]=0; lw/sw need addr[1:0]=0. A violation gives err 10.
- Errors from illegal opcode or misalignment: the request is accepted, err_valid pulses in cycle T+1, and no memory access happens.
- Byte order: little-endian. Byte k = word[8k+7:8k] with k = addr[1:0]; halfword h = word[16h+15:16h] with h = addr[1].
- Extension: lb/lh sign-extend; lbu/lhu zero-extend.
- States:
  - IDLE: on accept, latch the request; go to RD for loads, sb, sh; go to WR for sw.
  - RD: mem_req=1, mem_we=0. On mem_ack, latch mem_rdata.
    - Loads: go to IDLE; wb_valid=1, wb_rd=rt, wb_data=extracted value in the next cycle.
    - sb/sh: build the merged word (only the addressed byte or halfword replaced by req_wdata[7:0] or [15:0]) and go to WR.
  - WR: mem_req=1, mem_we=1, mem_wdata = merged word or req_wdata. On mem_ack go to IDLE; st_done=1 in the next cycle.
- Timing and handshake:
  - Accept at edge T. mem_req is high from T+1 and stays high, with address and data stable, until the cycle mem_ack is sampled. It drops the following cycle.
  - For sb/sh, mem_req stays high continuously across RD→WR; mem_we rises the cycle after the read ack.
  - Latency: ack in cycle T+1+k gives wb_valid/st_done at T+2+k. With k=0, a load takes 2 cycles and sb/sh takes at least 3.
- mem_ack sampled while mem_req=0 is ignored.
- The next request can be accepted in the same cycle wb_valid or st_done is high, since state is already IDLE.
- wb_rd=0 is still written back; suppressing $zero writes is the register file's job.

Optional Feature:
- LSU_TIMEOUT_EN defined:
  - A counter clears on each mem_req rising edge and increments while mem_req=1 and mem_ack=0.
  - On reaching TIMEOUT_CYCLES: abort to IDLE, drop mem_req, pulse err_valid with err_code 11 next cycle, no wb/st_done.
  - A late ack after abort is ignored.
- LSU_TIMEOUT_EN undefined: no counter; waits for mem_ack indefinitely; err_code 11 is never produced.

Test Plan:
- lw addr 0x10, memory returns 0xDEADBEEF with ack after 2 wait cycles, rt=5 → mem_addr=4, wb_valid one cycle with wb_rd=5, wb_data=0xDEADBEEF; latency 4 cycles.
- lb addr 0x13 then lbu addr 0x13, rdata 0x80FF1234 → wb_data 0xFFFFFF80, then 0x00000080.
- sb addr 0x01, wdata 0x000000AB, memory word 0x11223344 → read then write 0x1122AB44; mem_req held continuously; st_done pulses once.
- sh addr 0x03 → err_code 10, no mem_req. Opcode 0x3F → err_code 01.
- rst_n asserted mid-WR of sw → mem_req=0 immediately, no st_done; req_ready=1 after release; next lw completes normally.
- With LSU_TIMEOUT_EN, TIMEOUT_CYCLES=16, ack never arrives → err_code 11 after 16 cycles of mem_req; a late ack is ignored.

Source files
------------

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MEM-stage load/store initiator for a word-wide valid/ack data memory
// Optional build macro: LSU_TIMEOUT_EN (abort a memory access that is not acked within TIMEOUT_CYCLES)

module load_store_unit #(
  parameter int ADDR_W         = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [5:0]        req_opcode,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  input  logic [4:0]        req_rt,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              wb_valid,
  output logic [4:0]        wb_rd,
  output logic [31:0]       wb_data,
  output logic              st_done,
  output logic              err_valid,
  output logic [1:0]        err_code
);

  localparam logic [5:0] OP_LB  = 6'h20;
  localparam logic [5:0] OP_LH  = 6'h21;
  localparam logic [5:0] OP_LW  = 6'h23;
  localparam logic [5:0] OP_LBU = 6'h24;
  localparam logic [5:0] OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB  = 6'h28;
  localparam logic [5:0] OP_SH  = 6'h29;
  localparam logic [5:0] OP_SW  = 6'h2B;

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t      state;
  logic [5:0]  op_q;
  logic [1:0]  boff_q;
  logic [31:0] wdata_q;
  logic [4:0]  rt_q;

  logic is_load;
  logic is_store;
  logic misaligned;

  // Upper address bits select nothing: the memory is only 2^ADDR_W words deep
`ifdef LSU_TIMEOUT_EN
  logic unused_bits;
  assign unused_bits = ^req_addr[31:ADDR_W+2];
`else
  logic [31:0] unused_bits;
  assign unused_bits = {31'd0, ^req_addr[31:ADDR_W+2]} ^ 32'(TIMEOUT_CYCLES);
`endif

  assign req_ready = (state == IDLE);

  // Byte/halfword select from a little-endian word, then sign/zero extend
  function automatic logic [31:0] load_extract(input logic [5:0] op, input logic [1:0] boff,
                                               input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{boff, 3'b000} +: 8];
    h = w[{boff[1], 4'b0000} +: 16];
    case (op)
      OP_LB:   load_extract = {{24{b[7]}}, b};
      OP_LBU:  load_extract = {24'd0, b};
      OP_LH:   load_extract = {{16{h[15]}}, h};
      OP_LHU:  load_extract = {16'd0, h};
      default: load_extract = w;
    endcase
  endfunction

  // Replace only the addressed byte (sb) or halfword (sh) of the word read back
  function automatic logic [31:0] store_merge(input logic [5:0] op, input logic [1:0] boff,
                                              input logic [31:0] old_w, input logic [31:0] wd);
    logic [31:0] m;
    m = old_w;
    if (op == OP_SB) m[{boff, 3'b000} +: 8] = wd[7:0];
    else             m[{boff[1], 4'b0000} +: 16] = wd[15:0];
    store_merge = m;
  endfunction

  // Classify the incoming opcode and check its natural alignment
  always_comb begin
    is_load    = 1'b0;
    is_store   = 1'b0;
    misaligned = 1'b0;
    case (req_opcode)
      OP_LB, OP_LBU: is_load = 1'b1;
      OP_LH, OP_LHU: begin is_load = 1'b1;  misaligned = req_addr[0];    end
      OP_LW:         begin is_load = 1'b1;  misaligned = |req_addr[1:0]; end
      OP_SB:         is_store = 1'b1;
      OP_SH:         begin is_store = 1'b1; misaligned = req_addr[0];    end
      OP_SW:         begin is_store = 1'b1; misaligned = |req_addr[1:0]; end
      default: ;
    endcase
  end

`ifdef LSU_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [TO_W-1:0] to_cnt;
`endif

  // Request FSM with registered memory-port and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      op_q      <= '0;
      boff_q    <= '0;
      wdata_q   <= '0;
      rt_q      <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wb_valid  <= 1'b0;
      wb_rd     <= '0;
      wb_data   <= '0;
      st_done   <= 1'b0;
      err_valid <= 1'b0;
      err_code  <= '0;
`ifdef LSU_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      wb_valid  <= 1'b0;
      st_done   <= 1'b0;
      err_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (!(is_load || is_store)) begin
              err_valid <= 1'b1;
              err_code  <= 2'b01;
            end else if (misaligned) begin
              err_valid <= 1'b1;
              err_code  <= 2'b10;
            end else begin
              op_q     <= req_opcode;
              boff_q   <= req_addr[1:0];
              wdata_q  <= req_wdata;
              rt_q     <= req_rt;
              mem_addr <= req_addr[ADDR_W+1:2];
              mem_req  <= 1'b1;
              if (req_opcode == OP_SW) begin
                state     <= WR;
                mem_we    <= 1'b1;
                mem_wdata <= req_wdata;
              end else begin
                state  <= RD;
                mem_we <= 1'b0;
              end
            end
          end
        end
        RD: begin
          if (mem_ack) begin
            // Opcode bit 3 separates stores (0x28..0x2B) from loads (0x20..0x25)
            if (!op_q[3]) begin
              state    <= IDLE;
              mem_req  <= 1'b0;
              wb_valid <= 1'b1;
              wb_rd    <= rt_q;
              wb_data  <= load_extract(op_q, boff_q, mem_rdata);
            end else begin
              state     <= WR;
              mem_we    <= 1'b1;
              mem_wdata <= store_merge(op_q, boff_q, mem_rdata, wdata_q);
            end
          end
        end
        WR: begin
          if (mem_ack) begin
            state   <= IDLE;
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            st_done <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
`ifdef LSU_TIMEOUT_EN
      // mem_req only rises out of IDLE, so clearing in IDLE restarts the count per access
      if (state == IDLE) begin
        to_cnt <= '0;
      end else if (!mem_ack) begin
        if (to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
          state     <= IDLE;
          mem_req   <= 1'b0;
          mem_we    <= 1'b0;
          err_valid <= 1'b1;
          err_code  <= 2'b11;
        end else begin
          to_cnt <= to_cnt + 1'b1;
        end
      end
`endif
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed scoreboard bench for load_store_unit with a behavioural memory

module tb_load_store_unit;

  localparam int ADDR_W = 8;
  localparam int TO     = 16;

  logic              clk;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [5:0]        req_opcode;
  logic [31:0]       req_addr;
  logic [31:0]       req_wdata;
  logic [4:0]        req_rt;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic [31:0]       mem_rdata;
  logic              mem_ack;
  logic              wb_valid;
  logic [4:0]        wb_rd;
  logic [31:0]       wb_data;
  logic              st_done;
  logic              err_valid;
  logic [1:0]        err_code;

  load_store_unit #(.ADDR_W(ADDR_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_opcode(req_opcode),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_rt(req_rt),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
    .st_done(st_done), .err_valid(err_valid), .err_code(err_code)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 writeback, 1 store done, 2 error (data holds the err_code)
  typedef struct {
    int          kind;
    logic [4:0]  rd;
    logic [31:0] data;
    int          t_acc;
    int          lat;
  } exp_t;
  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       data;
  } wr_t;

  exp_t ev_q[$];
  wr_t  wr_q[$];

  int tests = 0;
  int fails = 0;

  logic [31:0]       mem_model [256];
  bit                ack_en    = 1'b1;
  int                ack_wait  = 0;
  bit                force_ack = 1'b0;
  logic [ADDR_W-1:0] exp_maddr = '0;
  int                req_rises = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Memory: acks ack_wait cycles after mem_req, applies writes, checks expected write words
  initial begin : responder
    int   wc;
    logic prev_req;
    wr_t  w;
    wc = 0;
    prev_req = 1'b0;
    mem_ack = 1'b0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      if (mem_req && !prev_req) req_rises++;
      prev_req = mem_req;
      mem_ack = 1'b0;
      if (force_ack) begin
        mem_ack   = 1'b1;
        mem_rdata = 32'h5A5A5A5A;
        force_ack = 1'b0;
      end else if (mem_req && ack_en) begin
        if (wc < ack_wait) wc++;
        else begin
          wc = 0;
          mem_ack = 1'b1;
          check("mem_addr", 32'(mem_addr), 32'(exp_maddr));
          if (mem_we) begin
            check("wr_pending", 32'(wr_q.size()), 32'd1);
            if (wr_q.size() > 0) begin
              w = wr_q.pop_front();
              check("wr_data", mem_wdata, w.data);
            end
            mem_model[mem_addr] = mem_wdata;
          end else begin
            mem_rdata = mem_model[mem_addr];
          end
        end
      end else begin
        wc = 0;
      end
    end
  end

  // Result monitor: every pulse must match the oldest expected event
  initial begin : monitor
    int   kind;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && (wb_valid || st_done || err_valid)) begin
        kind = wb_valid ? 0 : (st_done ? 1 : 2);
        check("one_pulse", 32'(wb_valid) + 32'(st_done) + 32'(err_valid), 32'd1);
        check("ev_pending", 32'(ev_q.size() > 0), 32'd1);
        if (ev_q.size() > 0) begin
          e = ev_q.pop_front();
          check("kind", 32'(kind), 32'(e.kind));
          check("latency", 32'(cyc + 1 - e.t_acc), 32'(e.lat));
          if (kind == 0) begin
            check("wb_rd", 32'(wb_rd), 32'(e.rd));
            check("wb_data", wb_data, e.data);
          end
          if (kind == 2) check("err_code", 32'(err_code), e.data);
        end
      end
    end
  end

  task automatic issue(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] wd,
                       input logic [4:0] rt, input int kind, input logic [31:0] exp_data,
                       input int lat);
    int n;
    @(negedge clk);
    req_valid  = 1'b1;
    req_opcode = op;
    req_addr   = addr;
    req_wdata  = wd;
    req_rt     = rt;
    exp_maddr  = addr[ADDR_W+1:2];
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    check("req_ready", 32'(req_ready), 32'd1);
    ev_q.push_back('{kind, rt, exp_data, cyc + 1, lat});
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    while (ev_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    check("drained", 32'(ev_q.size()), 32'd0);
  endtask

  initial begin : stimulus
    int r0;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_opcode = '0;
    req_addr = '0;
    req_wdata = '0;
    req_rt = '0;
    for (int i = 0; i < 256; i++) mem_model[i] = 32'hA5000000 | 32'(i);
    repeat (2) @(negedge clk);
    check("rst_req_ready", 32'(req_ready), 32'd1);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_wb_valid", 32'(wb_valid), 32'd0);
    check("rst_st_done", 32'(st_done), 32'd0);
    check("rst_err_valid", 32'(err_valid), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    rst_n = 1'b1;

    // lw with two wait cycles
    mem_model[4] = 32'hDEADBEEF;
    ack_wait = 2;
    issue(6'h23, 32'h10, 0, 5'd5, 0, 32'hDEADBEEF, 4);
    ack_wait = 0;

    // sub-word loads with extension
    mem_model[4] = 32'h80FF1234;
    issue(6'h20, 32'h13, 0, 5'd6, 0, 32'hFFFFFF80, 2);
    issue(6'h24, 32'h13, 0, 5'd7, 0, 32'h00000080, 2);
    issue(6'h21, 32'h12, 0, 5'd8, 0, 32'hFFFF80FF, 2);
    issue(6'h25, 32'h10, 0, 5'd9, 0, 32'h00001234, 2);

    // sb read-modify-write, mem_req held across both phases
    mem_model[0] = 32'h11223344;
    wr_q.push_back('{8'd0, 32'h1122AB44});
    r0 = req_rises;
    issue(6'h28, 32'h01, 32'h000000AB, 5'd0, 1, 0, 3);
    check("sb_req_rises", 32'(req_rises - r0), 32'd1);
    check("sb_mem_word", mem_model[0], 32'h1122AB44);

    // sh with one wait cycle on both phases
    mem_model[8] = 32'hAABBCCDD;
    wr_q.push_back('{8'd8, 32'h5566CCDD});
    ack_wait = 1;
    issue(6'h29, 32'h22, 32'hFFFF5566, 5'd0, 1, 0, 5);
    ack_wait = 0;

    // sw then lw back with upper address bits set and rt=0
    wr_q.push_back('{8'd12, 32'hCAFEF00D});
    issue(6'h2B, 32'h30, 32'hCAFEF00D, 5'd0, 1, 0, 2);
    issue(6'h23, 32'hFFFF0030, 0, 5'd0, 0, 32'hCAFEF00D, 2);

    // errors: no memory access
    r0 = req_rises;
    issue(6'h29, 32'h03, 0, 5'd1, 2, 32'd2, 1);
    issue(6'h23, 32'h02, 0, 5'd1, 2, 32'd2, 1);
    issue(6'h21, 32'h01, 0, 5'd1, 2, 32'd2, 1);
    issue(6'h3F, 32'h00, 0, 5'd1, 2, 32'd1, 1);
    check("err_req_rises", 32'(req_rises - r0), 32'd0);

    // stray ack while idle is ignored
    force_ack = 1'b1;
    repeat (3) @(negedge clk);
    check("stray_ack_ready", 32'(req_ready), 32'd1);
    check("stray_ack_mem_req", 32'(mem_req), 32'd0);

    // reset in the middle of a stalled sw write
    ack_en = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_opcode = 6'h2B; req_addr = 32'h40; req_wdata = 32'h01234567;
    @(posedge clk);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("wr_stall_mem_req", 32'(mem_req), 32'd1);
    check("wr_stall_mem_we", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    #1;
    check("midrst_mem_req", 32'(mem_req), 32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    ack_en = 1'b1;
    repeat (2) @(negedge clk);
    check("midrst_ready_after", 32'(req_ready), 32'd1);
    check("midrst_mem_word", mem_model[16], 32'hA5000010);
    issue(6'h23, 32'h10, 0, 5'd9, 0, 32'h80FF1234, 2);

`ifdef LSU_TIMEOUT_EN
    // memory never acks: abort after TO cycles of mem_req, late ack ignored
    ack_en = 1'b0;
    issue(6'h23, 32'h10, 0, 5'd3, 2, 32'd3, TO + 1);
    check("to_mem_req", 32'(mem_req), 32'd0);
    force_ack = 1'b1;
    repeat (3) @(negedge clk);
    check("to_late_ack_ready", 32'(req_ready), 32'd1);
    ack_en = 1'b1;
    issue(6'h23, 32'h10, 0, 5'd4, 0, 32'h80FF1234, 2);
`endif

    repeat (3) @(negedge clk);
    check("ev_q_empty", 32'(ev_q.size()), 32'd0);
    check("wr_q_empty", 32'(wr_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
